fetch_stage: RTL and testbench

- Instruction fetch stage sitting directly downstream of the program memory.
- Drives the 4-bit program address and captures the returned 46-bit line: {addr tag[3:0], rsvd[1:0], op[3:0], opA[11:0], opB[11:0], opC[11:0]}.
- Resolves jumps (op 4'h2) locally and issues all other instructions to the execute stage through a registered valid/ready handshake.
- Owns the program counter, wrap-around, stalls and the jump-range error flag.

---
 rtl/fetch_stage.sv | 133 +++++++++++++
 tb/tb_fetch_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, jump resolution and
// registered valid/ready issue toward execute.
module fetch_stage #(
  parameter int         PROG_LEN = 7,
  parameter logic [3:0] JUMP_OP  = 4'h2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [3:0]  addr,
  input  logic [45:0] line,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [3:0]  ins_pc,
  output logic [3:0]  ins_op,
  output logic [11:0] ins_a,
  output logic [11:0] ins_b,
  output logic [11:0] ins_c,
  output logic        jump_err
);

  typedef struct packed {
    logic [3:0]  tag;
    logic [1:0]  rsvd;
    logic [3:0]  op;
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] c;
  } line_t;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  localparam logic [3:0] PC_LAST = 4'(PROG_LEN - 1);
  localparam logic [4:0] PC_LIM  = 5'(PROG_LEN);

  line_t      ln;
  logic [3:0] pc;
  logic [3:0] pc_inc;
  logic [3:0] pc_nxt;
  logic [3:0] tgt;
  logic       slot_free;
  logic       advance;
  logic       is_jump;
  logic       jmp_ok;
  logic       jmp_bad;
  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       unused_rsvd;

  assign ln          = line_t'(line);
  assign unused_rsvd = ^ln.rsvd;
  assign addr        = pc;

  assign slot_free = !ins_valid || ins_ready;
  assign advance   = en && slot_free;
  assign is_jump   = (ln.op == JUMP_OP);
  assign tgt       = ln.a[3:0];
  assign jmp_ok    = is_jump && ({1'b0, tgt} < PC_LIM);
  assign jmp_bad   = is_jump && !jmp_ok;
  assign pc_inc    = (pc == PC_LAST) ? 4'd0 : pc + 4'd1;

  // next PC: jump target, out-of-range reset, or wrap increment
  always_comb begin
    pc_nxt = pc_inc;
    unique case (1'b1)
      jmp_ok:  pc_nxt = tgt;
      jmp_bad: pc_nxt = 4'd0;
      default: pc_nxt = pc_inc;
    endcase
  end

  // program counter moves only when the issue slot can take a word
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 4'd0;
    end else if (advance) begin
      pc <= pc_nxt;
    end
  end

  // issue register; a jump leaves a bubble and keeps old data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ins_valid <= 1'b0;
      ins_pc    <= 4'd0;
      ins_op    <= 4'd0;
      ins_a     <= 12'd0;
      ins_b     <= 12'd0;
      ins_c     <= 12'd0;
    end else if (advance) begin
      ins_valid <= !is_jump;
      if (!is_jump) begin
        ins_pc <= ln.tag;
        ins_op <= ln.op;
        ins_a  <= ln.a;
        ins_b  <= ln.b;
        ins_c  <= ln.c;
      end
    end else if (ins_ready) begin
      ins_valid <= 1'b0;
    end
  end

  // sticky out-of-range jump flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jump_err <= 1'b0;
    end else if (advance && jmp_bad) begin
      jump_err <= 1'b1;
    end
  end

  // RUN/STALL tracking of a held, un-accepted instruction
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (ins_valid && !ins_ready) state_nxt = STALL;
      STALL:   if (ins_ready) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plan steps plus a random
// program/handshake run against a program-walk model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        ins_ready = 1'b0;
  logic [3:0]  addr;
  logic [45:0] line;
  logic        ins_valid;
  logic [3:0]  ins_pc;
  logic [3:0]  ins_op;
  logic [11:0] ins_a;
  logic [11:0] ins_b;
  logic [11:0] ins_c;
  logic        jump_err;

  logic [45:0] prog [16];
  int          checks = 0;
  int          failures = 0;
  int          mpc = 0;

  always #5 clk = ~clk;

  assign line = prog[addr];

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .addr(addr),
    .line(line),
    .ins_valid(ins_valid),
    .ins_ready(ins_ready),
    .ins_pc(ins_pc),
    .ins_op(ins_op),
    .ins_a(ins_a),
    .ins_b(ins_b),
    .ins_c(ins_c),
    .jump_err(jump_err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [45:0] mk(
    input logic [3:0] tag, input logic [3:0] op,
    input logic [11:0] a, input logic [11:0] b,
    input logic [11:0] c);
    return {tag, 2'b11, op, a, b, c};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 16; i++)
      prog[i] = mk(4'(i), 4'h0, 12'h0, 12'h0, 12'h0);
  endtask

  task automatic load_toggle();
    clear_prog();
    prog[0] = mk(4'd0, 4'h1, 12'd150, 12'h801, 12'h0);
    prog[1] = mk(4'd1, 4'h0, 12'h0, 12'h0, 12'h0);
    prog[2] = mk(4'd2, 4'h8, 12'h0, 12'h0, 12'h0);
    prog[3] = mk(4'd3, 4'h2, 12'h001, 12'h0, 12'h0);
  endtask

  // Walk the program as an ISA would: jumps are
  // followed silently, anything else is the next issue.
  task automatic model_next(output logic [45:0] w);
    w = '0;
    for (int k = 0; k < 40; k++) begin
      w = prog[mpc];
      if (w[39:36] == 4'h2) begin
        mpc = int'(w[27:24]);
      end else begin
        mpc = (mpc == 6) ? 0 : mpc + 1;
        return;
      end
    end
  endtask

  initial begin : main
    int          exp_v [8];
    int          exp_pc [8];
    logic [45:0] w;
    logic        jf [7];
    int          t;
    int          acc;

    exp_v  = '{1, 1, 1, 0, 1, 1, 0, 1};
    exp_pc = '{0, 1, 2, 0, 1, 2, 0, 1};

    // reset state
    load_toggle();
    en = 1'b1;
    ins_ready = 1'b1;
    #2;
    chk("rst_valid", ins_valid, 1'b0);
    chk("rst_addr", addr, 4'd0);
    chk("rst_err", jump_err, 1'b0);
    chk("rst_data", {ins_pc, ins_op, ins_a, ins_b, ins_c}, 0);

    // toggle program, free-running
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("tog_v%0d", i), ins_valid, exp_v[i]);
      if (exp_v[i] == 1)
        chk($sformatf("tog_pc%0d", i), ins_pc, exp_pc[i]);
      if (i == 0) begin
        chk("tog_op", ins_op, 4'h1);
        chk("tog_a", ins_a, 12'd150);
        chk("tog_b", ins_b, 12'h801);
      end
    end
    chk("tog_err", jump_err, 1'b0);

    // downstream stall after pc0
    ins_ready = 1'b0;
    do_reset();
    tick();
    chk("stl_v0", ins_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_hold_v", ins_valid, 1'b1);
      chk("stl_hold_pc", ins_pc, 4'd0);
      chk("stl_hold_a", ins_a, 12'd150);
      chk("stl_addr", addr, 4'd1);
    end
    ins_ready = 1'b1;
    tick();
    chk("stl_rel_pc", ins_pc, 4'd1);
    chk("stl_rel_v", ins_valid, 1'b1);
    tick();
    chk("stl_next_pc", ins_pc, 4'd2);

    // straight-line program wraps at 7
    clear_prog();
    for (int i = 0; i < 7; i++)
      prog[i] = mk(4'(i), 4'h5, 12'(i * 3), 12'h0, 12'h0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("lin_v", ins_valid, 1'b1);
      chk($sformatf("lin_pc%0d", i), ins_pc, i % 7);
    end

    // en=0 for 4 cycles with one pending instruction
    do_reset();
    tick();
    tick();
    chk("en_pre_pc", ins_pc, 4'd1);
    en = 1'b0;
    ins_ready = 1'b0;
    tick();
    chk("en_hold_v", ins_valid, 1'b1);
    chk("en_hold_pc", ins_pc, 4'd1);
    chk("en_hold_addr", addr, 4'd2);
    ins_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_drain_v", ins_valid, 1'b0);
      chk("en_drain_addr", addr, 4'd2);
    end
    en = 1'b1;
    tick();
    chk("en_resume_v", ins_valid, 1'b1);
    chk("en_resume_pc", ins_pc, 4'd2);

    // out-of-range jump (A[3:0]=9, upper bits ignored)
    clear_prog();
    prog[0] = mk(4'd0, 4'h1, 12'h0, 12'h0, 12'h0);
    prog[1] = mk(4'd1, 4'h2, 12'hFA9, 12'h0, 12'h0);
    do_reset();
    tick();
    chk("jr_first_pc", ins_pc, 4'd0);
    chk("jr_err0", jump_err, 1'b0);
    tick();
    chk("jr_bubble", ins_valid, 1'b0);
    chk("jr_err1", jump_err, 1'b1);
    chk("jr_addr", addr, 4'd0);
    tick();
    chk("jr_next_v", ins_valid, 1'b1);
    chk("jr_next_pc", ins_pc, 4'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("jr_sticky", jump_err, 1'b1);

    // async reset while stalled
    ins_ready = 1'b0;
    tick();
    tick();
    chk("ar_stalled", ins_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", ins_valid, 1'b0);
    chk("ar_addr", addr, 4'd0);
    chk("ar_err", jump_err, 1'b0);
    #1;
    rst = 1'b1;
    tick();
    chk("ar_reissue_v", ins_valid, 1'b1);
    chk("ar_reissue_pc", ins_pc, 4'd0);

    // random programs and handshakes vs. program walk
    for (int r = 0; r < 4; r++) begin
      clear_prog();
      for (int i = 0; i < 7; i++)
        jf[i] = (i != 0) && ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 7; i++) begin
        if (jf[i]) begin
          t = $urandom_range(0, 6);
          if (jf[t]) t = 0;
          prog[i] = mk($urandom_range(0, 15), 4'h2,
                       {8'($urandom), 4'(t)},
                       12'($urandom), 12'($urandom));
        end else begin
          t = $urandom_range(0, 15);
          if (t == 2) t = 3;
          prog[i] = mk($urandom_range(0, 15), 4'(t),
                       12'($urandom), 12'($urandom),
                       12'($urandom));
        end
        prog[i][41:40] = 2'($urandom);
      end
      mpc = 0;
      acc = 0;
      en = 1'b1;
      ins_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 300; i++) begin
        en = ($urandom_range(0, 3) != 0);
        ins_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (ins_valid && ins_ready) begin
          model_next(w);
          acc++;
          chk("rand_issue",
              {ins_pc, ins_op, ins_a, ins_b, ins_c},
              {w[45:42], w[39:0]});
        end
        @(posedge clk);
        #1;
      end
      chk("rand_err", jump_err, 1'b0);
      chk("rand_progress", acc > 50, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
